// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue.
//   ZeroWord        : value driven on instruction outputs when nothing valid is present
//   DefaultResetPc  : default fetch start address
//   fetch_state_e   : fetch controller states (halted, fetching, loader owns memory)
package ifetch_queue_pkg;

   localparam logic [31:0] ZeroWord       = 32'h0000_0000;
   localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

   typedef enum logic [1:0] {
      StHalt = 2'd0,
      StRun  = 2'd1,
      StLoad = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/ifetch_queue_fifo_sync.sv
// Generic synchronous FIFO with synchronous clear.
//   clk, rst   : clock, asynchronous active-low reset
//   clr_i      : drop all entries (wins over push/pop)
//   push_i     : write wdata_i (accepted when not full, or when a pop frees a slot)
//   pop_i      : discard head entry (ignored when empty)
//   rdata_o    : head entry
//   count_o    : occupancy, 0..DEPTH
//   empty_o    : no entries
//   full_o     : DEPTH entries
module fifo_sync #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CntW'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   // A full queue may still take a push when the head leaves in the same cycle.
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: it is only observed through a non-empty head.
   always_ff @(posedge clk) begin
      if (do_push && !clr_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch unit: owns the fetch PC, issues sequential reads to a synchronous-read
// instruction memory and buffers {pc, instr} pairs for decode. Supports redirect/flush and
// hands the memory port to the UART program loader.
//   clk, rst          : clock, asynchronous active-low reset
//   inited_i          : fetching allowed while high
//   upg_*_i           : loader port (active flag, write strobe, address, data)
//   redirect_i/_pc_i  : branch/jump redirect and byte target
//   id_ready_i        : decode accepts head entry
//   if_valid_o/pc/instr : head entry towards decode
//   mem_*             : instruction memory port
//   fetch_cnt_o       : instructions accepted by decode (wrapping)
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int unsigned ADDR_W   = 14,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DefaultResetPc
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inited_i,
   input  logic              upg_active_i,
   input  logic              upg_wen_i,
   input  logic [ADDR_W:0]   upg_adr_i,
   input  logic [DATA_W-1:0] upg_dat_i,
   input  logic              redirect_i,
   input  logic [31:0]       redirect_pc_i,
   input  logic              id_ready_i,
   output logic              if_valid_o,
   output logic [31:0]       if_pc_o,
   output logic [DATA_W-1:0] if_instr_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [31:0]       fetch_cnt_o
);

   localparam int unsigned PcW    = ADDR_W + 2;
   localparam int unsigned CntW   = $clog2(DEPTH) + 1;
   localparam int unsigned EntryW = 32 + DATA_W;
   localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

   fetch_state_e      state_q, state_d;
   logic [PcW-1:0]    fetch_pc_q, fetch_pc_d;
   logic              inflight_q, inflight_d;
   logic [31:0]       inflight_pc_q, inflight_pc_d;
   logic [31:0]       fetch_cnt_q, fetch_cnt_d;

   logic              q_clr, q_push, q_pop;
   logic              q_empty, q_full;
   logic [CntW-1:0]   q_count;
   logic [EntryW-1:0] q_rdata;
   logic [CntW:0]     occ;
   logic              credit_ok;
   logic              issue;

   fifo_sync #(
      .WIDTH (EntryW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (q_clr),
      .push_i  (q_push),
      .wdata_i ({inflight_pc_q, mem_rdata_i}),
      .pop_i   (q_pop),
      .rdata_o (q_rdata),
      .count_o (q_count),
      .empty_o (q_empty),
      .full_o  (q_full)
   );

   // Queue control and read issue. Redirect, loader takeover and loss of init all flush;
   // the flush also suppresses this cycle's push, which is what kills an in-flight read.
   always_comb begin
      q_clr  = upg_active_i | redirect_i | ((state_q == StRun) & ~inited_i);
      q_pop  = ~q_empty & id_ready_i & ~q_clr;
      q_push = inflight_q & ~q_clr;
      // The in-flight read is charged at issue time, so a response always finds room.
      occ       = {1'b0, q_count} + {{CntW{1'b0}}, inflight_q};
      credit_ok = q_pop ? (occ <= DepthLim) : (occ < DepthLim);
      issue     = (state_q == StRun) & inited_i & ~upg_active_i & ~redirect_i & credit_ok;
   end

   always_comb begin
      state_d = state_q;
      if (upg_active_i) begin
         state_d = StLoad;
      end else begin
         case (state_q)
            StHalt:  if (inited_i)  state_d = StRun;
            StRun:   if (!inited_i) state_d = StHalt;
            StLoad:  state_d = StHalt;
            default: state_d = StHalt;
         endcase
      end
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = issue;
      inflight_pc_d = issue ? 32'(fetch_pc_q) : inflight_pc_q;
      fetch_cnt_d   = fetch_cnt_q + (q_pop ? 32'd1 : 32'd0);
      // Held at RESET_PC for the whole upload so fetch restarts there when it ends.
      if (state_q == StLoad) begin
         fetch_pc_d = RESET_PC[PcW-1:0];
      end else if ((state_q == StRun) && redirect_i) begin
         fetch_pc_d = {redirect_pc_i[PcW-1:2], 2'b00};
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + PcW'(4);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StHalt;
         fetch_pc_q    <= RESET_PC[PcW-1:0];
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         fetch_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         fetch_cnt_q   <= fetch_cnt_d;
      end
   end

   // Memory port: loader drives it in LOAD; addresses with the MSB set target data memory.
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (state_q)
         StLoad: begin
            mem_en_o    = upg_wen_i & ~upg_adr_i[ADDR_W];
            mem_we_o    = upg_wen_i & ~upg_adr_i[ADDR_W];
            mem_addr_o  = upg_adr_i[ADDR_W-1:0];
            mem_wdata_o = upg_dat_i;
         end
         StRun: begin
            mem_en_o   = issue;
            mem_addr_o = issue ? fetch_pc_q[PcW-1:2] : '0;
         end
         default: ;
      endcase
   end

   assign if_valid_o  = ~q_empty;
   assign if_pc_o     = q_empty ? 32'h0 : q_rdata[EntryW-1:DATA_W];
   assign if_instr_o  = q_empty ? DATA_W'(ZeroWord) : q_rdata[DATA_W-1:0];
   assign fetch_cnt_o = fetch_cnt_q;

   logic unused_bits;
   assign unused_bits = ^{redirect_pc_i[31:PcW], redirect_pc_i[1:0], q_full};

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

   localparam int AW       = 14;
   localparam int DW       = 32;
   localparam int DEP      = 4;
   localparam int MemWords = 1 << AW;

   logic          clk;
   logic          rst;
   logic          inited;
   logic          upg_active;
   logic          upg_wen;
   logic [AW:0]   upg_adr;
   logic [DW-1:0] upg_dat;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          id_ready;
   logic          if_valid_o;
   logic [31:0]   if_pc_o;
   logic [DW-1:0] if_instr_o;
   logic          mem_en_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata;
   logic [31:0]   fetch_cnt_o;

   ifetch_queue #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .DEPTH    (DEP),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .inited_i      (inited),
      .upg_active_i  (upg_active),
      .upg_wen_i     (upg_wen),
      .upg_adr_i     (upg_adr),
      .upg_dat_i     (upg_dat),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .id_ready_i    (id_ready),
      .if_valid_o    (if_valid_o),
      .if_pc_o       (if_pc_o),
      .if_instr_o    (if_instr_o),
      .mem_en_o      (mem_en_o),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_rdata_i   (mem_rdata),
      .fetch_cnt_o   (fetch_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read instruction memory; word k initially holds k.
   logic [31:0] mem_q [MemWords];
   logic        mem_init;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MemWords; i++) mem_q[i] <= i;
      end else if (mem_en_o) begin
         if (mem_we_o) mem_q[mem_addr_o] <= mem_wdata_o;
         else          mem_rdata <= mem_q[mem_addr_o];
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s", name);
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t sb_q[$];

   task automatic sb_push(input logic [31:0] pc, input logic [31:0] instr);
      exp_t e;
      e.pc    = pc;
      e.instr = instr;
      sb_q.push_back(e);
   endtask

   // Accept n head entries and compare each against the scoreboard. Call at posedge+1.
   task automatic expect_pops(input int n, input int limit, input string tag);
      int   got = 0;
      int   cyc = 0;
      exp_t e;
      id_ready = 1'b1;
      while (got < n && cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (if_valid_o) begin
            if (sb_q.size() == 0) begin
               fail_now({tag, "_unexpected_entry"});
            end else begin
               e = sb_q.pop_front();
               chk({tag, "_pc"}, if_pc_o, e.pc);
               chk({tag, "_instr"}, if_instr_o, e.instr);
            end
            got++;
         end
      end
      if (got < n) chk({tag, "_pop_timeout"}, got, n);
      @(posedge clk);
      #1 id_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst        = 1'b0;
      redirect   = 1'b0;
      upg_active = 1'b0;
      upg_wen    = 1'b0;
      id_ready   = 1'b0;
      inited     = 1'b1;
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   typedef struct {
      logic        id_ready;
      logic        exp_en;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      logic [31:0] exp_cnt;
   } vec_t;
   vec_t vecs[21];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n_rd;
      logic [31:0] rd_addr [8];

      // Startup/streaming table: row k is cycle k after reset release, id_ready held high.
      for (int k = 0; k < 21; k++) begin
         vecs[k].id_ready  = 1'b1;
         vecs[k].exp_en    = (k >= 1);
         vecs[k].exp_addr  = (k >= 1) ? k - 1 : 0;
         vecs[k].exp_valid = (k >= 3);
         vecs[k].exp_pc    = (k >= 3) ? 4 * (k - 3) : 0;
         vecs[k].exp_instr = (k >= 3) ? k - 3 : 0;
         vecs[k].exp_cnt   = (k >= 3) ? k - 3 : 0;
      end

      rst = 1'b0; inited = 1'b0; upg_active = 1'b0; upg_wen = 1'b0; upg_adr = '0;
      upg_dat = '0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
      mem_init = 1'b1;
      @(posedge clk);
      #1 mem_init = 1'b0;

      // Reset holds every output low whatever the inputs do.
      for (int i = 0; i < 4; i++) begin
         inited      = 1'($urandom);
         upg_active  = 1'($urandom);
         upg_wen     = 1'($urandom);
         upg_adr     = (AW + 1)'($urandom);
         upg_dat     = $urandom;
         redirect    = 1'($urandom);
         redirect_pc = $urandom;
         id_ready    = 1'($urandom);
         @(negedge clk);
         chk("rst_if_valid", if_valid_o, 0);
         chk("rst_if_pc", if_pc_o, 0);
         chk("rst_if_instr", if_instr_o, 0);
         chk("rst_mem_en", mem_en_o, 0);
         chk("rst_mem_we", mem_we_o, 0);
         chk("rst_mem_addr", mem_addr_o, 0);
         chk("rst_fetch_cnt", fetch_cnt_o, 0);
         @(posedge clk);
         #1;
      end

      // Release and stream.
      inited = 1'b1; upg_active = 1'b0; upg_wen = 1'b0; redirect = 1'b0;
      rst = 1'b1;
      for (int r = 0; r < 21; r++) begin
         id_ready = vecs[r].id_ready;
         @(negedge clk);
         chk($sformatf("stream%0d_mem_en", r), mem_en_o, vecs[r].exp_en);
         if (vecs[r].exp_en) chk($sformatf("stream%0d_mem_addr", r), mem_addr_o, vecs[r].exp_addr);
         chk($sformatf("stream%0d_valid", r), if_valid_o, vecs[r].exp_valid);
         chk($sformatf("stream%0d_pc", r), if_pc_o, vecs[r].exp_pc);
         chk($sformatf("stream%0d_instr", r), if_instr_o, vecs[r].exp_instr);
         chk($sformatf("stream%0d_cnt", r), fetch_cnt_o, vecs[r].exp_cnt);
      end
      @(posedge clk);
      #1 id_ready = 1'b0;
      @(negedge clk);
      chk("stream_final_cnt", fetch_cnt_o, 18);

      // Backpressure: exactly DEPTH reads, then drain in order.
      do_reset();
      n_rd = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (mem_en_o) begin
            if (n_rd < 8) rd_addr[n_rd] = 32'(mem_addr_o);
            n_rd++;
         end
      end
      chk("bp_read_count", n_rd, DEP);
      for (int j = 0; j < DEP; j++) begin
         if (j < n_rd) chk($sformatf("bp_read_addr%0d", j), rd_addr[j], j);
      end
      chk("bp_head_valid", if_valid_o, 1);
      chk("bp_head_pc", if_pc_o, 0);
      for (int j = 0; j < 8; j++) sb_push(4 * j, j);
      @(posedge clk);
      #1 expect_pops(8, 40, "bp");
      chk("bp_cnt", fetch_cnt_o, 8);

      // Redirect with two entries queued and one read in flight.
      do_reset();
      repeat (4) @(posedge clk);
      #1 redirect = 1'b1;
      redirect_pc = 32'h0000_0103;
      @(negedge clk);
      chk("redir_q_occupied", if_valid_o, 1);
      chk("redir_no_issue", mem_en_o, 0);
      @(posedge clk);
      #1 redirect = 1'b0;
      sb_q.delete();
      for (int j = 0; j < 4; j++) sb_push(32'h100 + 4 * j, 32'h40 + j);
      @(negedge clk);
      chk("redir_flushed", if_valid_o, 0);
      chk("redir_issue_en", mem_en_o, 1);
      chk("redir_issue_addr", mem_addr_o, 32'h40);
      @(posedge clk);
      #1 expect_pops(4, 20, "redir");

      // Back-to-back redirects: last one wins.
      redirect = 1'b1;
      redirect_pc = 32'h0000_0200;
      @(posedge clk);
      #1 redirect_pc = 32'h0000_0303;
      @(posedge clk);
      #1 redirect = 1'b0;
      sb_q.delete();
      sb_push(32'h300, 32'hC0);
      expect_pops(1, 10, "redir2");
      chk("redir_cnt", fetch_cnt_o, 5);

      // Upload: instruction-memory write passes, data-memory write is dropped.
      upg_active = 1'b1;
      @(posedge clk);
      #1 upg_wen = 1'b1;
      upg_adr = {1'b0, 14'd5};
      upg_dat = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("upg_mem_en", mem_en_o, 1);
      chk("upg_mem_we", mem_we_o, 1);
      chk("upg_mem_addr", mem_addr_o, 5);
      chk("upg_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      chk("upg_no_valid", if_valid_o, 0);
      @(posedge clk);
      #1 upg_adr = {1'b1, 14'd5};
      upg_dat = 32'h1111_1111;
      @(negedge clk);
      chk("upg_dmem_en", mem_en_o, 0);
      chk("upg_dmem_we", mem_we_o, 0);
      @(posedge clk);
      #1 upg_wen = 1'b0;
      upg_active = 1'b0;
      sb_q.delete();
      for (int j = 0; j < 7; j++) sb_push(4 * j, (j == 5) ? 32'hDEAD_BEEF : j);
      expect_pops(7, 30, "upg");
      chk("upg_cnt", fetch_cnt_o, 12);

      // Asynchronous reset with the queue full.
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("full_valid", if_valid_o, 1);
      chk("full_no_issue", mem_en_o, 0);
      #2 rst = 1'b0;
      #1;
      chk("async_valid", if_valid_o, 0);
      chk("async_pc", if_pc_o, 0);
      chk("async_instr", if_instr_o, 0);
      chk("async_mem_en", mem_en_o, 0);
      chk("async_cnt", fetch_cnt_o, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      sb_q.delete();
      for (int j = 0; j < 3; j++) sb_push(4 * j, j);
      expect_pops(3, 20, "restart");
      chk("restart_cnt", fetch_cnt_o, 3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
